// File: rtl/bip_control_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bip_control_unit: BIP instruction sequencer (pc, decode, control strobes). Rev 1.0
// ---------------------------------------------------------------------------
module bip_control_unit #(
  parameter int ADDRESS_BITS = 11,
  parameter int DATA_BITS    = 16,
  parameter int OPCODE_BITS  = 5,
  parameter int COUNT_BITS   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [DATA_BITS-1:0]    i_instruction,
  output logic [ADDRESS_BITS-1:0] o_pc,
  output logic [ADDRESS_BITS-1:0] o_data_addr,
  output logic [DATA_BITS-1:0]    o_operand,
  output logic [1:0]              o_sel_a,
  output logic                    o_sel_b,
  output logic                    o_op,
  output logic                    o_wr_acc,
  output logic                    o_wr_ram,
  output logic                    o_rd_ram,
  output logic                    o_running,
  output logic                    o_halted,
  output logic [COUNT_BITS-1:0]   o_cycle_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [OPCODE_BITS-1:0] OP_HLT  = OPCODE_BITS'(0);
  localparam logic [OPCODE_BITS-1:0] OP_STO  = OPCODE_BITS'(1);
  localparam logic [OPCODE_BITS-1:0] OP_LD   = OPCODE_BITS'(2);
  localparam logic [OPCODE_BITS-1:0] OP_LDI  = OPCODE_BITS'(3);
  localparam logic [OPCODE_BITS-1:0] OP_ADD  = OPCODE_BITS'(4);
  localparam logic [OPCODE_BITS-1:0] OP_ADDI = OPCODE_BITS'(5);
  localparam logic [OPCODE_BITS-1:0] OP_SUB  = OPCODE_BITS'(6);
  localparam logic [OPCODE_BITS-1:0] OP_SUBI = OPCODE_BITS'(7);

  state_t                  state;
  state_t                  next_state;
  logic [ADDRESS_BITS-1:0] pc;
  logic [COUNT_BITS-1:0]   cycle_count;
  logic [OPCODE_BITS-1:0]  opcode;

  assign opcode      = i_instruction[DATA_BITS-1 -: OPCODE_BITS];
  assign o_data_addr = i_instruction[ADDRESS_BITS-1:0];
  assign o_operand   = {{(DATA_BITS-ADDRESS_BITS){i_instruction[ADDRESS_BITS-1]}},
                        i_instruction[ADDRESS_BITS-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      cycle_count <= '0;
    end else begin
      state <= next_state;
      case (state)
        RUN: begin
          if (cycle_count != {COUNT_BITS{1'b1}})
            cycle_count <= cycle_count + COUNT_BITS'(1);
          // HLT keeps pc on its own address so the halt point stays visible
          if (opcode != OP_HLT)
            pc <= pc + ADDRESS_BITS'(1);
        end
        HALT: begin
          if (i_start) begin
            pc          <= '0;
            cycle_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    o_sel_a    = 2'd0;
    o_sel_b    = 1'b0;
    o_op       = 1'b0;
    o_wr_acc   = 1'b0;
    o_wr_ram   = 1'b0;
    o_rd_ram   = 1'b0;
    case (state)
      IDLE: if (i_start) next_state = RUN;
      RUN: begin
        case (opcode)
          OP_HLT:  next_state = HALT;
          OP_STO:  o_wr_ram = 1'b1;
          OP_LD:   begin o_rd_ram = 1'b1; o_wr_acc = 1'b1; end
          OP_LDI:  begin o_sel_a = 2'd1; o_wr_acc = 1'b1; end
          OP_ADD:  begin o_rd_ram = 1'b1; o_sel_a = 2'd2; o_wr_acc = 1'b1; end
          OP_ADDI: begin o_sel_a = 2'd2; o_sel_b = 1'b1; o_wr_acc = 1'b1; end
          OP_SUB:  begin o_rd_ram = 1'b1; o_sel_a = 2'd2; o_op = 1'b1; o_wr_acc = 1'b1; end
          OP_SUBI: begin o_sel_a = 2'd2; o_sel_b = 1'b1; o_op = 1'b1; o_wr_acc = 1'b1; end
          default: ;
        endcase
      end
      HALT: if (i_start) next_state = RUN;
      default: next_state = IDLE;
    endcase
  end

  assign o_pc          = pc;
  assign o_cycle_count = cycle_count;
  assign o_running     = (state == RUN);
  assign o_halted      = (state == HALT);

endmodule
`default_nettype wire

// File: tb/tb_bip_control_unit.sv
`default_nettype none
// tb_bip_control_unit: directed vectors against hand-computed control words.
module tb_bip_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] instruction;
  logic [10:0] pc, data_addr;
  logic [15:0] operand;
  logic [1:0]  sel_a;
  logic        sel_b, op, wr_acc, wr_ram, rd_ram, running, halted;
  logic [31:0] cycle_count;
  logic [6:0]  ctl;

  logic        rst4 = 1'b0;
  logic        start4 = 1'b0;
  logic [15:0] instruction4;
  logic [10:0] pc4, data_addr4;
  logic [15:0] operand4;
  logic [1:0]  sel_a4;
  logic        sel_b4, op4, wr_acc4, wr_ram4, rd_ram4, running4, halted4;
  logic [3:0]  cycle_count4;

  logic [15:0] mem [0:2047];
  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  assign instruction  = mem[pc];
  assign instruction4 = 16'h4000;  // NOP everywhere: never halts
  assign ctl = {sel_a, sel_b, op, wr_acc, wr_ram, rd_ram};

  bip_control_unit dut (
    .clk(clk), .rst(rst), .i_start(start), .i_instruction(instruction),
    .o_pc(pc), .o_data_addr(data_addr), .o_operand(operand),
    .o_sel_a(sel_a), .o_sel_b(sel_b), .o_op(op), .o_wr_acc(wr_acc),
    .o_wr_ram(wr_ram), .o_rd_ram(rd_ram), .o_running(running),
    .o_halted(halted), .o_cycle_count(cycle_count)
  );

  bip_control_unit #(.COUNT_BITS(4)) dut4 (
    .clk(clk), .rst(rst4), .i_start(start4), .i_instruction(instruction4),
    .o_pc(pc4), .o_data_addr(data_addr4), .o_operand(operand4),
    .o_sel_a(sel_a4), .o_sel_b(sel_b4), .o_op(op4), .o_wr_acc(wr_acc4),
    .o_wr_ram(wr_ram4), .o_rd_ram(rd_ram4), .o_running(running4),
    .o_halted(halted4), .o_cycle_count(cycle_count4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    rst = 1'b1; rst4 = 1'b1;
    tick();
    rst = 1'b0; rst4 = 1'b0;
    vectors++;
    if ({pc, cycle_count, running, halted, ctl} !== {11'd0, 32'd0, 1'b0, 1'b0, 7'd0}) begin
      $display("FAIL reset_state: pc=%0d cnt=%0d run=%b halt=%b ctl=%b, expected all zero",
               pc, cycle_count, running, halted, ctl);
      errors++;
    end
    tick();
    vectors++;
    if (running !== 1'b0 || pc !== 11'd0) begin
      $display("FAIL idle_hold: run=%b pc=%0d, expected run=0 pc=0", running, pc);
      errors++;
    end
  endtask

  task automatic test_program();
    mem[0] = 16'h1FFC;  // LDI -4
    mem[1] = 16'h0801;  // STO 1
    mem[2] = 16'h1802;  // LDI 2
    mem[3] = 16'h2001;  // ADD 1
    mem[4] = 16'h0802;  // STO 2
    mem[5] = 16'h0000;  // HLT
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (running !== 1'b1 || pc !== 11'd0 || cycle_count !== 32'd0) begin
      $display("FAIL start_run: run=%b pc=%0d cnt=%0d, expected 1 0 0", running, pc, cycle_count);
      errors++;
    end
    vectors++;
    if (operand !== 16'hFFFC || ctl !== 7'b01_0_0_1_0_0) begin
      $display("FAIL ldi_neg: operand=%h ctl=%b, expected fffc 0100100", operand, ctl);
      errors++;
    end
    tick();
    vectors++;
    if (ctl !== 7'b00_0_0_0_1_0 || data_addr !== 11'd1 || pc !== 11'd1) begin
      $display("FAIL sto: ctl=%b addr=%0d pc=%0d, expected 0000010 1 1", ctl, data_addr, pc);
      errors++;
    end
    tick();
    tick();
    vectors++;
    if (ctl !== 7'b10_0_0_1_0_1 || data_addr !== 11'd1) begin
      $display("FAIL add: ctl=%b addr=%0d, expected 1000101 1", ctl, data_addr);
      errors++;
    end
    tick();
    tick();
    vectors++;
    if (pc !== 11'd5 || ctl !== 7'd0 || running !== 1'b1) begin
      $display("FAIL hlt_decode: pc=%0d ctl=%b run=%b, expected 5 0000000 1", pc, ctl, running);
      errors++;
    end
    tick();
    vectors++;
    if (halted !== 1'b1 || running !== 1'b0 || pc !== 11'd5 || cycle_count !== 32'd6) begin
      $display("FAIL halt_entry: halt=%b run=%b pc=%0d cnt=%0d, expected 1 0 5 6",
               halted, running, pc, cycle_count);
      errors++;
    end
    mem[5] = 16'h1805;  // LDI 5 under the halted pc: must not strobe
    #1;
    vectors++;
    if (ctl !== 7'd0 || operand !== 16'h0005 || data_addr !== 11'd5) begin
      $display("FAIL halt_quiet: ctl=%b operand=%h addr=%0d, expected 0000000 0005 5",
               ctl, operand, data_addr);
      errors++;
    end
    tick();
    vectors++;
    if (halted !== 1'b1 || pc !== 11'd5 || cycle_count !== 32'd6) begin
      $display("FAIL halt_hold: halt=%b pc=%0d cnt=%0d, expected 1 5 6", halted, pc, cycle_count);
      errors++;
    end
  endtask

  task automatic test_subtract();
    mem[0] = 16'h3832;  // SUBI 50
    mem[1] = 16'h3001;  // SUB 1
    mem[2] = 16'h0000;  // HLT
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (pc !== 11'd0 || cycle_count !== 32'd0 || running !== 1'b1) begin
      $display("FAIL restart: pc=%0d cnt=%0d run=%b, expected 0 0 1", pc, cycle_count, running);
      errors++;
    end
    vectors++;
    if (ctl !== 7'b10_1_1_1_0_0 || operand !== 16'd50) begin
      $display("FAIL subi: ctl=%b operand=%0d, expected 1011100 50", ctl, operand);
      errors++;
    end
    tick();
    vectors++;
    if (ctl !== 7'b10_0_1_1_0_1 || data_addr !== 11'd1) begin
      $display("FAIL sub: ctl=%b addr=%0d, expected 1001101 1", ctl, data_addr);
      errors++;
    end
    tick();
    tick();
    vectors++;
    if (halted !== 1'b1 || pc !== 11'd2 || cycle_count !== 32'd3) begin
      $display("FAIL sub_halt: halt=%b pc=%0d cnt=%0d, expected 1 2 3", halted, pc, cycle_count);
      errors++;
    end
  endtask

  task automatic test_nop_and_start_in_run();
    mem[0] = 16'h4000;  // opcode 01000: undefined, acts as NOP
    mem[1] = 16'h0000;  // HLT
    start = 1'b1;
    tick();
    vectors++;
    if (ctl !== 7'd0 || pc !== 11'd0 || running !== 1'b1) begin
      $display("FAIL nop: ctl=%b pc=%0d run=%b, expected 0000000 0 1", ctl, pc, running);
      errors++;
    end
    tick();  // start still high during RUN
    start = 1'b0;
    vectors++;
    if (pc !== 11'd1 || cycle_count !== 32'd1 || running !== 1'b1) begin
      $display("FAIL start_in_run: pc=%0d cnt=%0d run=%b, expected 1 1 1", pc, cycle_count, running);
      errors++;
    end
    tick();
    vectors++;
    if (halted !== 1'b1 || pc !== 11'd1 || cycle_count !== 32'd2) begin
      $display("FAIL nop_halt: halt=%b pc=%0d cnt=%0d, expected 1 1 2", halted, pc, cycle_count);
      errors++;
    end
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 4; i++) mem[i] = 16'h2801;  // ADDI 1
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    vectors++;
    if (pc !== 11'd2 || ctl !== 7'b10_1_0_1_0_0) begin
      $display("FAIL addi: pc=%0d ctl=%b, expected 2 1010100", pc, ctl);
      errors++;
    end
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    vectors++;
    if ({pc, cycle_count, running, halted, ctl} !== {11'd0, 32'd0, 1'b0, 1'b0, 7'd0}) begin
      $display("FAIL reset_mid_run: pc=%0d cnt=%0d run=%b halt=%b ctl=%b, expected all zero",
               pc, cycle_count, running, halted, ctl);
      errors++;
    end
    tick();
    vectors++;
    if (running !== 1'b0 || pc !== 11'd0) begin
      $display("FAIL reset_idle: run=%b pc=%0d, expected 0 0", running, pc);
      errors++;
    end
  endtask

  task automatic test_wrap_saturate();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    repeat (2047) tick();
    vectors++;
    if (pc4 !== 11'd2047 || cycle_count4 !== 4'd15 || running4 !== 1'b1) begin
      $display("FAIL pc_top: pc=%0d cnt=%0d run=%b, expected 2047 15 1", pc4, cycle_count4, running4);
      errors++;
    end
    tick();
    vectors++;
    if (pc4 !== 11'd0 || cycle_count4 !== 4'd15 || running4 !== 1'b1) begin
      $display("FAIL pc_wrap: pc=%0d cnt=%0d run=%b, expected 0 15 1", pc4, cycle_count4, running4);
      errors++;
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_program();
    test_subtract();
    test_nop_and_start_in_run();
    test_reset_mid_run();
    test_wrap_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
